// File: rtl/timer_pkg.sv
// Shared APB slave definitions: FSM state encoding and register-offset geometry.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Registers are word-aligned: index lives in paddr[5:2], everything above must be zero.
  localparam int unsigned REG_STRIDE = 4;
  localparam int unsigned IDX_LSB    = 2;
  localparam int unsigned IDX_MSB    = 5;
  localparam int unsigned MAP_LSB    = 6;
  localparam int unsigned MAX_REGS   = 16;
  localparam int unsigned CNT_W      = 4;

  function automatic int unsigned reg_offset(input int unsigned idx);
    return idx * REG_STRIDE;
  endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state counter for the ACCESS phase; done_o flags that WAIT_CYC cycles have elapsed.
module apb_wait_cnt
  import timer_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CNT_W'(WAIT_CYC));

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave front-end for a register block: decode, wait states, error response and
// one-cycle read/write strobes toward the register file.
module apb_reg_slave
  import timer_pkg::*;
#(
  parameter int                  ADDR_W    = 12,
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 8,
  parameter int                  WAIT_CYC  = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0] LOCK_MASK = '0
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic                pslverr,
  output logic [DATA_W-1:0]   prdata,
  input  logic                lock,
  input  logic                ext_err,
  output logic                wr_en,
  output logic                rd_en,
  output logic [3:0]          reg_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  input  logic [DATA_W-1:0]   rd_data
);

  localparam logic [MAX_REGS-1:0] RO_EXT   = MAX_REGS'(RO_MASK);
  localparam logic [MAX_REGS-1:0] LOCK_EXT = MAX_REGS'(LOCK_MASK);

  apb_state_e state_q, state_d;
  logic       xfer_ok;
  logic       cnt_done;
  logic       cnt_clear;
  logic       mapped;
  logic       wr_err;
  logic       acc_err;
  logic       ready_int;

  assign reg_idx = paddr[IDX_MSB:IDX_LSB];
  assign wr_data = pwdata;
  assign wr_strb = pstrb;

  assign mapped = (paddr[IDX_LSB-1:0] == '0) && (paddr[ADDR_W-1:MAP_LSB] == '0) &&
                  (int'(reg_idx) < NUM_REGS);

  // An all-zero strobe write touches nothing, so protection and field checks do not apply.
  assign wr_err  = pwrite && (pstrb != '0) &&
                   (RO_EXT[reg_idx] || (lock && LOCK_EXT[reg_idx]) || ext_err);
  assign acc_err = !mapped || wr_err;

  assign xfer_ok   = psel && penable;
  assign ready_int = (state_q == ACCESS) && xfer_ok && cnt_done;

  assign pready  = ready_int;
  assign pslverr = ready_int && acc_err;
  assign wr_en   = ready_int && pwrite && !acc_err && (pstrb != '0);
  assign rd_en   = ready_int && !pwrite && mapped;
  assign prdata  = rd_en ? rd_data : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (psel) state_d = SETUP;
      end
      SETUP: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!xfer_ok) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = psel ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding the counter clear outside ACCESS guarantees it reads zero on ACCESS entry.
  assign cnt_clear = (state_q != ACCESS) || (state_d != ACCESS);

  apb_wait_cnt #(
    .WAIT_CYC(WAIT_CYC)
  ) u_wait_cnt (
    .clk     (pclk),
    .rst_n   (prst_n),
    .clear_i (cnt_clear),
    .enable_i(state_q == ACCESS),
    .done_o  (cnt_done)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances with WAIT_CYC = 1, 0 and 3 share one bus.
module tb_apb_reg_slave;
  import timer_pkg::*;

  logic             pclk = 1'b0;
  logic             prst_n;
  logic [2:0]       psel_v;
  logic             penable, pwrite, lock, ext_err;
  logic [11:0]      paddr;
  logic [31:0]      pwdata, rd_data;
  logic [3:0]       pstrb;
  logic [2:0]       pready_v, pslverr_v, wr_en_v, rd_en_v;
  logic [2:0][31:0] prdata_v, wr_data_v;
  logic [2:0][3:0]  reg_idx_v, wr_strb_v;

  int n_assert = 0;
  int n_fail   = 0;

  int          lat, nwr, nrd;
  logic        err;
  logic [31:0] rdat, wdat;
  logic [3:0]  idx, wstb;

  always #5 pclk = ~pclk;

  // Instance 0: WAIT_CYC=1, instance 1: WAIT_CYC=0, instance 2: WAIT_CYC=3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    apb_reg_slave #(
      .ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .WAIT_CYC(WC),
      .RO_MASK(8'h04), .LOCK_MASK(8'h02)
    ) u_dut (
      .pclk   (pclk),
      .prst_n (prst_n),
      .psel   (psel_v[g]),
      .penable(penable),
      .pwrite (pwrite),
      .paddr  (paddr),
      .pwdata (pwdata),
      .pstrb  (pstrb),
      .pready (pready_v[g]),
      .pslverr(pslverr_v[g]),
      .prdata (prdata_v[g]),
      .lock   (lock),
      .ext_err(ext_err),
      .wr_en  (wr_en_v[g]),
      .rd_en  (rd_en_v[g]),
      .reg_idx(reg_idx_v[g]),
      .wr_data(wr_data_v[g]),
      .wr_strb(wr_strb_v[g]),
      .rd_data(rd_data)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge; returns just after the rising edge that follows pready.
  task automatic xfer(input int k, input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic hold);
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = d;
    pstrb     = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 0; nwr = 0; nrd = 0; err = 1'b0;
    rdat = '0; wdat = '0; idx = '0; wstb = '0;
    while (lat < 20) begin
      @(negedge pclk);
      lat++;
      nwr += int'(wr_en_v[k]);
      nrd += int'(rd_en_v[k]);
      if (pready_v[k]) begin
        err  = pslverr_v[k];
        rdat = prdata_v[k];
        wdat = wr_data_v[k];
        wstb = wr_strb_v[k];
        idx  = reg_idx_v[k];
        break;
      end
    end
    @(posedge pclk); #1;
    penable = 1'b0;
    if (!hold) psel_v[k] = 1'b0;
  endtask

  initial begin
    prst_n = 1'b0; psel_v = '0; penable = 1'b0; pwrite = 1'b0; lock = 1'b0; ext_err = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; rd_data = '0;

    repeat (2) @(negedge pclk);
    check("rst_pready",  32'(pready_v[0]),  32'h0);
    check("rst_pslverr", 32'(pslverr_v[0]), 32'h0);
    check("rst_wr_en",   32'(wr_en_v[0]),   32'h0);
    check("rst_rd_en",   32'(rd_en_v[0]),   32'h0);
    check("rst_prdata",  prdata_v[0],       32'h0);
    check("rst_state",   32'(g_dut[0].u_dut.state_q), 32'(IDLE));
    #2 prst_n = 1'b1;
    @(posedge pclk); #1;

    // WAIT_CYC=1 write to reg 0: one SETUP cycle, then pready in the second ACCESS cycle.
    xfer(0, 1'b1, 12'h000, 32'h0000_0302, 4'hF, 1'b0);
    check("w0_lat",   lat,  3);
    check("w0_wr_en", nwr,  1);
    check("w0_err",   32'(err), 32'h0);
    check("w0_wdata", wdat, 32'h0000_0302);
    check("w0_wstrb", 32'(wstb), 32'hF);
    check("w0_idx",   32'(idx),  32'h0);

    xfer(0, 1'b1, 12'h040, 32'h1, 4'hF, 1'b0);
    check("unmap_lat",   lat, 3);
    check("unmap_err",   32'(err), 32'h1);
    check("unmap_wr_en", nwr, 0);

    lock = 1'b1;
    xfer(0, 1'b1, 12'h004, 32'h55, 4'hF, 1'b0);
    check("lock_err",   32'(err), 32'h1);
    check("lock_wr_en", nwr, 0);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'hF, 1'b0);
    check("ro_rd_locked_err", 32'(err), 32'h0);
    check("ro_rd_locked_rd",  nrd, 1);
    lock = 1'b0;
    xfer(0, 1'b1, 12'h004, 32'h55, 4'hF, 1'b0);
    check("unlock_err",   32'(err), 32'h0);
    check("unlock_wr_en", nwr, 1);
    check("unlock_idx",   32'(idx), 32'h1);

    xfer(0, 1'b1, 12'h008, 32'h77, 4'h3, 1'b0);
    check("ro_wr_err",   32'(err), 32'h1);
    check("ro_wr_wr_en", nwr, 0);

    xfer(0, 1'b1, 12'h006, 32'h77, 4'hF, 1'b0);
    check("misalign_err",   32'(err), 32'h1);
    check("misalign_wr_en", nwr, 0);

    ext_err = 1'b1;
    xfer(0, 1'b1, 12'h000, 32'h99, 4'hF, 1'b0);
    check("ext_err_err",   32'(err), 32'h1);
    check("ext_err_wr_en", nwr, 0);
    ext_err = 1'b0;

    xfer(0, 1'b1, 12'h000, 32'h99, 4'h0, 1'b0);
    check("zstrb_lat",   lat, 3);
    check("zstrb_err",   32'(err), 32'h0);
    check("zstrb_wr_en", nwr, 0);

    // WAIT_CYC=0 read: pready in the first ACCESS cycle.
    rd_data = 32'hA5A5_A5A5;
    xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 1'b0);
    check("rd3_lat",    lat,  2);
    check("rd3_rd_en",  nrd,  1);
    check("rd3_prdata", rdat, 32'hA5A5_A5A5);
    check("rd3_err",    32'(err), 32'h0);
    check("rd3_idx",    32'(idx), 32'h3);

    xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0);
    check("rd_unmap_err",    32'(err), 32'h1);
    check("rd_unmap_prdata", rdat, 32'h0);
    check("rd_unmap_rd_en",  nrd, 0);

    xfer(2, 1'b1, 12'h000, 32'h1234, 4'hF, 1'b0);
    check("w3_lat",   lat, 5);
    check("w3_wr_en", nwr, 1);

    // WAIT_CYC=3: drop psel after two ACCESS cycles.
    psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    nwr = 0; lat = 0;
    repeat (3) begin
      @(negedge pclk);
      nwr += int'(wr_en_v[2]);
      lat += int'(pready_v[2]);
    end
    @(posedge pclk); #1;
    psel_v[2] = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      nwr += int'(wr_en_v[2]);
      lat += int'(pready_v[2]);
    end
    check("abort_pready", lat, 0);
    check("abort_wr_en",  nwr, 0);
    check("abort_state",  32'(g_dut[2].u_dut.state_q), 32'(IDLE));
    check("abort_cnt",    32'(g_dut[2].u_dut.u_wait_cnt.cnt_q), 32'h0);
    @(posedge pclk); #1;

    // Back-to-back writes on the WAIT_CYC=0 instance.
    xfer(1, 1'b1, 12'h000, 32'hAAAA, 4'hF, 1'b1);
    check("b2b_first_wr_en", nwr, 1);
    check("b2b_state_setup", 32'(g_dut[1].u_dut.state_q), 32'(SETUP));
    xfer(1, 1'b1, 12'h004, 32'hBBBB, 4'hF, 1'b0);
    check("b2b_second_wr_en", nwr, 1);
    check("b2b_second_lat",   lat, 2);
    check("b2b_second_wdata", wdat, 32'hBBBB);

    // Reset asserted while pready/rd_en are high must clear every output at once.
    rd_data = 32'hA5A5_A5A5;
    psel_v[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h00C;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    check("pre_rst_pready", 32'(pready_v[1]), 32'h1);
    #2 prst_n = 1'b0;
    #1;
    check("mid_rst_pready",  32'(pready_v[1]),  32'h0);
    check("mid_rst_rd_en",   32'(rd_en_v[1]),   32'h0);
    check("mid_rst_prdata",  prdata_v[1],       32'h0);
    check("mid_rst_pslverr", 32'(pslverr_v[1]), 32'h0);
    check("mid_rst_wr_en",   32'(wr_en_v[1]),   32'h0);
    psel_v[1] = 1'b0; penable = 1'b0;
    @(posedge pclk); #3 prst_n = 1'b1;
    @(posedge pclk); #1;

    rd_data = 32'h1234_5678;
    xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 1'b0);
    check("post_rst_lat",    lat,  2);
    check("post_rst_prdata", rdat, 32'h1234_5678);
    check("post_rst_rd_en",  nrd,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 8, 16, 32.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of word-aligned registers starting at offset 0; legal range 1..16.
REQ-004 SHALL have parameter WAIT_CYC, default 1, wait states per transfer; legal range 0..15.
REQ-005 SHALL have parameter RO_MASK, default 0, NUM_REGS bits; bit i set means register i is read-only.
REQ-006 SHALL have parameter LOCK_MASK, default 0, NUM_REGS bits; bit i set means register i is write-protected while lock=1.
REQ-007 SHALL have port pclk, input, 1, clock; all logic on the rising edge.
REQ-008 SHALL have port prst_n, input, 1; reset is asynchronous and active-low.
REQ-009 SHALL have ports psel, penable, pwrite, input, 1 each, APB control.
REQ-010 SHALL have port paddr, input, ADDR_W, byte address.
REQ-011 SHALL have port pwdata, input, DATA_W, write data; port pstrb, input, DATA_W/8, byte strobes.
REQ-012 SHALL have ports pready and pslverr, output, 1 each; port prdata, output, DATA_W.
REQ-013 SHALL have port lock, input, 1, write-protect enable (tied to timer running).
REQ-014 SHALL have port ext_err, input, 1, combinational field-legality error from the register block for the current wr_data/wr_strb/reg_idx.
REQ-015 SHALL have ports wr_en and rd_en, output, 1 each, one-cycle access strobes.
REQ-016 SHALL have ports reg_idx, output, 4, decoded register index; wr_data, output, DATA_W; wr_strb, output, DATA_W/8.
REQ-017 SHALL have port rd_data, input, DATA_W, register read value for reg_idx.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP on psel=1; SETUP -> ACCESS on psel=1 and penable=1; SETUP -> IDLE on psel=0; SETUP holds otherwise.
REQ-019 SHALL run a wait counter in ACCESS, cleared on ACCESS entry; pready asserts when count == WAIT_CYC, so pready rises WAIT_CYC cycles after the first ACCESS cycle, and in that first cycle when WAIT_CYC=0.
REQ-020 SHALL, on the pready cycle, go to SETUP if psel=1, else to IDLE.
REQ-021 SHALL abort to IDLE if psel or penable drops in ACCESS before pready; no strobe, no pready, counter cleared.
REQ-022 SHALL decode reg_idx = paddr[5:2]; address is mapped iff paddr[1:0]==0, paddr[ADDR_W-1:6]==0 and reg_idx < NUM_REGS.
REQ-023 SHALL assert pslverr only together with pready, when any of: unmapped or misaligned address; write to an RO_MASK register; write to a LOCK_MASK register while lock=1; write with ext_err=1.
REQ-024 SHALL pulse wr_en for exactly the pready cycle when pwrite=1 and pslverr=0; wr_data=pwdata and wr_strb=pstrb, passed through combinationally.
REQ-025 SHALL treat a write with pstrb all-zero as a legal no-op: pready asserts, pslverr=0, wr_en=0.
REQ-026 SHALL pulse rd_en on the pready cycle when pwrite=0 and the address is mapped; prdata=rd_data in that cycle, else all-zero.
REQ-027 SHALL give a read of an unmapped address pslverr=1, prdata=0 and rd_en=0; reads ignore lock and RO_MASK.
REQ-028 SHALL support back-to-back transfers: SETUP follows pready directly with no IDLE cycle.

Reset
REQ-029 SHALL, on prst_n=0, force IDLE, counter=0, pready=0, pslverr=0, wr_en=0, rd_en=0, prdata=0, at any time including mid-ACCESS, and suppress any strobe.
REQ-030 SHALL start the first transfer after reset release with the next psel=1.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE, SETUP, ACCESS) and the register-offset constants in shared package timer_pkg.
REQ-032 SHALL use one sub-module, apb_wait_cnt: the wait counter, inputs clear/enable, output done.

Verification
REQ-033 Write reg 0, WAIT_CYC=1, pstrb=4'hF, data 0x0000_0302 -> pready 1 cycle after ACCESS entry, wr_en one pulse, pslverr=0.
REQ-034 Write to paddr 0x040, NUM_REGS=8 -> pslverr=1 with pready, wr_en=0.
REQ-035 lock=1 and write to a LOCK_MASK register -> pslverr=1, wr_en=0; same write with lock=0 -> wr_en=1.
REQ-036 Read reg 3, rd_data=0xA5A5_A5A5, WAIT_CYC=0 -> pready, rd_en and prdata=0xA5A5_A5A5 in the first ACCESS cycle.
REQ-037 psel drops mid-wait with WAIT_CYC=3 -> IDLE next cycle, no pready, no strobe; prst_n low mid-ACCESS -> all outputs 0 immediately.
REQ-038 Two back-to-back writes -> SETUP directly after the first pready, two wr_en pulses, no IDLE cycle between.
